// File: rtl/lc3Pkg.sv
// Shared LC-3 types: memory-arbiter FSM states, owner encoding and the latched command record.
package lc3Pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP
  } ArbStates;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam logic [7:0] CNT_MAX = 8'hFF;

  // One requester's view of a memory access, captured at grant time.
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } MemCmd;

endpackage

// File: rtl/lc3_sat_counter.sv
// 8-bit up counter that sticks at its maximum; clear wins over increment.
module lc3_sat_counter
  import lc3Pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Two-master arbiter for the single LC-3 memory port: CPU has priority, DMA is protected from
// starvation, and a hung access is aborted after TIMEOUT busy cycles (TIMEOUT 0..256, 0 = off).
module lc3_mem_arbiter
  import lc3Pkg::*;
#(
  parameter int unsigned DMA_MAX_WAIT = 8,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_rdy,
  output logic        cpu_err,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_rdy,
  output logic        dma_err,
  output logic [15:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        owner
);

  localparam logic [7:0] StarveLimit = 8'(DMA_MAX_WAIT);
  localparam logic [7:0] ToLast      = (TIMEOUT == 0) ? 8'h00 : 8'(TIMEOUT - 1);

  ArbStates   state;
  logic [7:0] starveCnt;
  logic [7:0] toCnt;
  logic       cpuWin;
  logic       dmaWin;
  logic       timedOut;
  logic       starveInc;
  logic       starveClr;
  logic       toInc;
  logic       toClr;
  MemCmd      winCmd;

  // Arbitration only happens in ARB_IDLE; requests seen elsewhere are ignored.
  always_comb begin
    cpuWin = 1'b0;
    dmaWin = 1'b0;
    if (state == ARB_IDLE) begin
      if (cpu_req && dma_req) begin
        if (starveCnt >= StarveLimit) begin
          dmaWin = 1'b1;
        end else begin
          cpuWin = 1'b1;
        end
      end else begin
        cpuWin = cpu_req;
        dmaWin = dma_req;
      end
    end
  end

  always_comb begin
    winCmd = dmaWin ? MemCmd'{we: dma_we, addr: dma_addr, wdata: dma_wdata}
                    : MemCmd'{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  end

  // DMA waits both while losing in IDLE and while a CPU access it queued behind is in flight.
  always_comb begin
    starveInc = dma_req && (((state == ARB_IDLE) && !dmaWin) ||
                            ((state != ARB_IDLE) && (owner == OWN_CPU)));
    starveClr = dmaWin;
    toInc     = (state == ARB_BUSY);
    toClr     = (state == ARB_RESP);
    timedOut  = (TIMEOUT != 0) && (toCnt == ToLast);
  end

  lc3_sat_counter u_starve_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (starveInc),
    .clr   (starveClr),
    .count (starveCnt)
  );

  lc3_sat_counter u_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (toInc),
    .clr   (toClr),
    .count (toCnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdy   <= 1'b0;
      cpu_err   <= 1'b0;
      dma_rdy   <= 1'b0;
      dma_err   <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      owner     <= OWN_CPU;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (cpuWin || dmaWin) begin
            mem_req   <= 1'b1;
            mem_we    <= winCmd.we;
            mem_addr  <= winCmd.addr;
            mem_wdata <= winCmd.wdata;
            owner     <= dmaWin ? OWN_DMA : OWN_CPU;
            busy      <= 1'b1;
            state     <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (mem_ack) begin
            rdata   <= mem_rdata;
            mem_req <= 1'b0;
            cpu_rdy <= (owner == OWN_CPU);
            dma_rdy <= (owner == OWN_DMA);
            state   <= ARB_RESP;
          end else if (timedOut) begin
            rdata   <= '0;
            mem_req <= 1'b0;
            cpu_rdy <= (owner == OWN_CPU);
            dma_rdy <= (owner == OWN_DMA);
            cpu_err <= (owner == OWN_CPU);
            dma_err <= (owner == OWN_DMA);
            state   <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          cpu_rdy <= 1'b0;
          dma_rdy <= 1'b0;
          cpu_err <= 1'b0;
          dma_err <= 1'b0;
          busy    <= 1'b0;
          state   <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: per-cycle vector table plus hand-written multi-cycle cases.
module tb_lc3_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req, cpu_we, dma_req, dma_we, mem_ack;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic        cpu_rdy, cpu_err, dma_rdy, dma_err, mem_req, mem_we, busy, owner;
  logic [15:0] rdata, mem_addr, mem_wdata;

  int nTests = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  lc3_mem_arbiter #(
    .DMA_MAX_WAIT (8),
    .TIMEOUT      (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdy   (cpu_rdy),
    .cpu_err   (cpu_err),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_rdy   (dma_rdy),
    .dma_err   (dma_err),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .owner     (owner)
  );

  typedef struct packed {
    logic        cpuReq;
    logic        cpuWe;
    logic [15:0] cpuAddr;
    logic [15:0] cpuWdata;
    logic        dmaReq;
    logic        dmaWe;
    logic [15:0] dmaAddr;
    logic [15:0] dmaWdata;
    logic        memAck;
    logic [15:0] memRdata;
  } vin_t;

  typedef struct packed {
    logic        memReq;
    logic        memWe;
    logic [15:0] memAddr;
    logic [15:0] memWdata;
    logic        cpuRdy;
    logic        cpuErr;
    logic        dmaRdy;
    logic        dmaErr;
    logic [15:0] rdata;
    logic        busy;
    logic        owner;
  } vexp_t;

  typedef struct {
    vin_t  in;
    vexp_t exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vin_t vi(logic cr, logic cw, logic [15:0] ca, logic [15:0] cd,
                              logic dr, logic dw, logic [15:0] da, logic [15:0] dd,
                              logic ack, logic [15:0] md);
    vin_t v;
    v.cpuReq = cr; v.cpuWe = cw; v.cpuAddr = ca; v.cpuWdata = cd;
    v.dmaReq = dr; v.dmaWe = dw; v.dmaAddr = da; v.dmaWdata = dd;
    v.memAck = ack; v.memRdata = md;
    return v;
  endfunction

  function automatic vexp_t ve(logic mr, logic mw, logic [15:0] ma, logic [15:0] md,
                               logic cr, logic ce, logic dr, logic de,
                               logic [15:0] rd, logic bz, logic ow);
    vexp_t e;
    e.memReq = mr; e.memWe = mw; e.memAddr = ma; e.memWdata = md;
    e.cpuRdy = cr; e.cpuErr = ce; e.dmaRdy = dr; e.dmaErr = de;
    e.rdata = rd; e.busy = bz; e.owner = ow;
    return e;
  endfunction

  task automatic add(input vin_t i, input vexp_t e);
    vec_t v;
    v.in  = i;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vin_t v);
    cpu_req   = v.cpuReq;
    cpu_we    = v.cpuWe;
    cpu_addr  = v.cpuAddr;
    cpu_wdata = v.cpuWdata;
    dma_req   = v.dmaReq;
    dma_we    = v.dmaWe;
    dma_addr  = v.dmaAddr;
    dma_wdata = v.dmaWdata;
    mem_ack   = v.memAck;
    mem_rdata = v.memRdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] starveOwn;
    logic [4:0] ownSeq;
    int         memReqCycles;
    int         rdyCount;
    logic       seenRdy;
    logic       o;

    drive(vi(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0));

    // CPU read x3000, two wait cycles, then ack with x1234.
    add(vi(1, 0, 16'h3000, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0),
        ve(1, 0, 16'h3000, 16'h0, 0, 0, 0, 0, 16'h0, 1, 0));
    add(vi(1, 0, 16'h3000, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0),
        ve(1, 0, 16'h3000, 16'h0, 0, 0, 0, 0, 16'h0, 1, 0));
    add(vi(1, 0, 16'h3000, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0),
        ve(1, 0, 16'h3000, 16'h0, 0, 0, 0, 0, 16'h0, 1, 0));
    add(vi(1, 0, 16'h3000, 16'h0, 0, 0, 16'h0, 16'h0, 1, 16'h1234),
        ve(0, 0, 16'h0, 16'h0, 1, 0, 0, 0, 16'h1234, 1, 0));
    add(vi(0, 0, 16'h3000, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0),
        ve(0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 16'h0, 0, 0));
    // Stray mem_ack in IDLE must be ignored.
    add(vi(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 16'hBEEF),
        ve(0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 16'h0, 0, 0));
    // DMA write x00FF to xFE00, ack in the first BUSY cycle.
    add(vi(0, 0, 16'h0, 16'h0, 1, 1, 16'hFE00, 16'h00FF, 0, 16'h0),
        ve(1, 1, 16'hFE00, 16'h00FF, 0, 0, 0, 0, 16'h0, 1, 1));
    add(vi(0, 0, 16'h0, 16'h0, 1, 1, 16'hFE00, 16'h00FF, 1, 16'h0000),
        ve(0, 0, 16'h0, 16'h0, 0, 0, 1, 0, 16'h0000, 1, 1));
    add(vi(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0),
        ve(0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 16'h0, 0, 1));
    // Both requesting, zero-wait memory: starve_cnt reaches 9 before the fourth contest.
    ownSeq = 5'b01000;
    for (int t = 0; t < 5; t++) begin
      o = ownSeq[t];
      add(vi(1, 0, 16'h1000, 16'h0, 1, 0, 16'h2000, 16'h0, 0, 16'h0),
          ve(1, 0, o ? 16'h2000 : 16'h1000, 16'h0, 0, 0, 0, 0, 16'h0, 1, o));
      add(vi(1, 0, 16'h1000, 16'h0, 1, 0, 16'h2000, 16'h0, 1, 16'hA000 + 16'(t)),
          ve(0, 0, 16'h0, 16'h0, !o, 0, o, 0, 16'hA000 + 16'(t), 1, o));
      // mem_ack during RESP is ignored.
      add(vi(1, 0, 16'h1000, 16'h0, 1, 0, 16'h2000, 16'h0, 1, 16'hFFFF),
          ve(0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 16'h0, 0, o));
    end
    add(vi(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0),
        ve(0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 16'h0, 0, 0));

    #12;
    check("reset.mem_req", mem_req, 0);
    check("reset.busy", busy, 0);
    check("reset.owner", owner, 0);
    check("reset.rdy", {cpu_rdy, dma_rdy, cpu_err, dma_err}, 0);
    check("reset.rdata", rdata, 16'h0);
    check("reset.mem_addr", mem_addr, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in);
      tick();
      check($sformatf("v%0d.mem_req", i), mem_req, vecs[i].exp.memReq);
      check($sformatf("v%0d.cpu_rdy", i), cpu_rdy, vecs[i].exp.cpuRdy);
      check($sformatf("v%0d.cpu_err", i), cpu_err, vecs[i].exp.cpuErr);
      check($sformatf("v%0d.dma_rdy", i), dma_rdy, vecs[i].exp.dmaRdy);
      check($sformatf("v%0d.dma_err", i), dma_err, vecs[i].exp.dmaErr);
      check($sformatf("v%0d.busy", i), busy, vecs[i].exp.busy);
      check($sformatf("v%0d.owner", i), owner, vecs[i].exp.owner);
      if (vecs[i].exp.memReq) begin
        check($sformatf("v%0d.mem_we", i), mem_we, vecs[i].exp.memWe);
        check($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].exp.memAddr);
        check($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].exp.memWdata);
      end
      if (vecs[i].exp.cpuRdy || vecs[i].exp.dmaRdy) begin
        check($sformatf("v%0d.rdata", i), rdata, vecs[i].exp.rdata);
      end
    end

    // Timeout: CPU read x5000, memory never acks; rdata must be forced to zero.
    drive(vi(1, 0, 16'h5000, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0));
    memReqCycles = 0;
    seenRdy = 1'b0;
    for (int k = 0; k < 12 && !seenRdy; k++) begin
      tick();
      if (mem_req) memReqCycles++;
      if (cpu_rdy) begin
        seenRdy = 1'b1;
        check("to.cpu_err", cpu_err, 1);
        check("to.rdata", rdata, 16'h0);
        check("to.dma_rdy", dma_rdy, 0);
        check("to.busy", busy, 1);
      end
    end
    check("to.seen_rdy", seenRdy, 1);
    check("to.mem_req_cycles", 16'(memReqCycles), 16'd4);
    cpu_req = 1'b0;
    tick();
    check("to.err_clear", cpu_err, 0);
    check("to.idle_busy", busy, 0);

    // Next request after the timeout, with cpu_addr changed mid-access.
    cpu_req  = 1'b1;
    cpu_addr = 16'h3000;
    tick();
    check("chg.mem_req", mem_req, 1);
    check("chg.addr0", mem_addr, 16'h3000);
    cpu_addr = 16'h4000;
    tick();
    check("chg.addr1", mem_addr, 16'h3000);
    mem_ack   = 1'b1;
    mem_rdata = 16'h5A5A;
    tick();
    check("chg.cpu_rdy", cpu_rdy, 1);
    check("chg.cpu_err", cpu_err, 0);
    check("chg.rdata", rdata, 16'h5A5A);
    check("chg.addr_resp", mem_addr, 16'h3000);
    mem_ack = 1'b0;
    cpu_req = 1'b0;
    tick();
    check("chg.idle", busy, 0);

    // Async reset during the second BUSY cycle.
    cpu_req  = 1'b1;
    cpu_addr = 16'h3000;
    tick();
    check("rst.busy1", mem_req, 1);
    tick();
    check("rst.busy2", mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.mem_req_now", mem_req, 0);
    check("rst.busy_now", busy, 0);
    cpu_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rdyCount = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (cpu_rdy) rdyCount++;
    end
    check("rst.no_rdy", 16'(rdyCount), 16'd0);
    check("rst.busy_after", busy, 0);
    check("rst.mem_req_after", mem_req, 0);

    // Idle check after reset: a fresh request still gets granted normally.
    cpu_req = 1'b1;
    tick();
    check("rst.regrant", mem_req, 1);
    starveOwn = {owner, busy, 1'b0};
    check("rst.regrant_own", starveOwn, 3'b010);
    cpu_req = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
Shares the single LC-3 memory port between two requesters: the CPU control path (fetch, load/store and interrupt stack traffic) and a DMA/debug master. Each requester sees its own req/rdy handshake, matching the control FSM's wait-on-ready style. The arbiter drives one multi-cycle memory interface and returns read data plus a one-cycle ready pulse. It gives the CPU priority, but guarantees DMA progress and flags a timeout on a hung memory access.

Parameters:
DMA_MAX_WAIT, 8, cycles DMA may wait while CPU keeps winning; when reached, DMA wins the next contested arbitration (1..255).
TIMEOUT, 64, maximum BUSY cycles without mem_ack before the access is aborted; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request; held until cpu_rdy
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  16  CPU address
cpu_wdata  in  16  CPU write data
cpu_rdy  out  1  one-cycle completion pulse
cpu_err  out  1  asserted with cpu_rdy when the access timed out
dma_req, dma_we, dma_addr, dma_wdata  in  1/1/16/16  DMA equivalents of the CPU inputs
dma_rdy, dma_err  out  1/1  DMA equivalents of cpu_rdy/cpu_err
rdata  out  16  read data, valid while cpu_rdy or dma_rdy is high
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  16  memory address
mem_wdata  out  16  memory write data
mem_ack  in  1  memory completion, one cycle
mem_rdata  in  16  memory read data, valid with mem_ack
busy  out  1  high in BUSY and RESP states
owner  out  1  0 = CPU, 1 = DMA; last granted requester

Behaviour:
- All outputs are registered. Reset values: every mem_*, *_rdy, *_err, rdata, busy and owner output is 0. State resets to ARB_IDLE and both counters reset to 0.
- Async reset mid-access: mem_req drops immediately, and no rdy pulse is issued for the aborted access.
- ARB_IDLE: at each edge, sample both requests.
  - Neither requesting: stay in ARB_IDLE.
  - Exactly one requesting: grant it.
  - Both requesting: grant the CPU, unless starve_cnt >= DMA_MAX_WAIT, in which case grant DMA.
- On grant: latch the winner's we, addr and wdata into the mem_* registers, set mem_req=1, set owner, and go to ARB_BUSY. mem_req is therefore high from the cycle after the request is sampled.
- ARB_BUSY: mem_* are held stable. The timeout counter increments each cycle.
  - If mem_ack is high: latch rdata <= mem_rdata (writes latch it too; the value is don't-care), drop mem_req, and go to ARB_RESP.
  - Else if TIMEOUT != 0 and the counter has reached TIMEOUT-1: drop mem_req, set rdata = 16'h0000, set the owner's err, and go to ARB_RESP.
- ARB_RESP: the owner's rdy is high for exactly one cycle (err alongside it on timeout). Then go to ARB_IDLE, clear err and the timeout counter.
- Latency with zero-wait memory (mem_ack in the first BUSY cycle): req sampled at edge N, mem_req high in cycle N+1, rdy high in cycle N+2.
  - Minimum spacing between grants is 3 cycles, because the IDLE cycle after RESP is mandatory.
  - That IDLE cycle lets a requester drop or renew req after seeing rdy.
- starve_cnt:
  - Increments (saturating at 255) in every ARB_IDLE cycle where dma_req=1 and DMA is not granted.
  - Also increments in BUSY/RESP cycles while dma_req=1 and owner=CPU.
  - Clears to 0 on a DMA grant.
- The non-owner's rdy and err stay 0. Its req is ignored until the next ARB_IDLE.
- Changing req, addr or data while BUSY has no effect, since the latched values are used.
- mem_ack seen in ARB_IDLE or ARB_RESP is ignored.

Decomposition:
- lc3Pkg gains the ArbStates enum {ARB_IDLE, ARB_BUSY, ARB_RESP}.
- lc3Pkg gains the owner constants OWN_CPU=1'b0 and OWN_DMA=1'b1.
- One sub-module: lc3_sat_counter, an 8-bit saturating counter with inc/clr/async rst_n. It is instantiated twice, for starve_cnt and the timeout counter.

Test Plan:
- CPU read of addr x3000, memory acks with x1234 after 2 wait cycles -> mem_req high for 3 cycles with mem_addr=x3000 and mem_we=0; cpu_rdy for 1 cycle with rdata=x1234; dma_rdy stays 0.
- CPU and DMA both request continuously, DMA_MAX_WAIT=8, zero-wait memory -> CPU wins the first contests; once starve_cnt>=8 the next grant goes to DMA (owner=1); starve_cnt returns to 0 and CPU wins again.
- DMA write x00FF to addr xFE00, ack on the first BUSY cycle -> mem_we=1, mem_wdata=x00FF, mem_addr=xFE00; dma_rdy 2 cycles after the request is sampled; dma_err=0.
- TIMEOUT=4, CPU read, mem_ack never asserted -> mem_req drops after 4 BUSY cycles; cpu_rdy=1, cpu_err=1, rdata=x0000; the next request is arbitrated normally.
- rst_n pulled low in the second BUSY cycle -> mem_req=0 immediately; after release there is no cpu_rdy, state is ARB_IDLE, and busy=0.
- CPU changes cpu_addr from x3000 to x4000 while BUSY -> mem_addr stays x3000 until RESP.
